// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among writeback sources.
// Writes to x0 are acknowledged immediately and never consume the write slot.
module regfile_wb_arbiter #(
  parameter int XLEN                 = 32,
  parameter int NUM_REQ              = 3,
  parameter int CNT_WIDTH            = 16,
  parameter int REGISTER_INDEX_WIDTH = 5
) (
  input  logic                                    clk,
  input  logic                                    n_rst,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ*REGISTER_INDEX_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]                 req_data,
  input  logic                                    hold,
  output logic                                    rd_wen,
  output logic [REGISTER_INDEX_WIDTH-1:0]         rd_addr,
  output logic [XLEN-1:0]                         rd_wdata,
  output logic [NUM_REQ-1:0]                      grant_onehot,
  output logic [CNT_WIDTH-1:0]                    contention_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] x0_hit;
  logic [NUM_REQ-1:0] nz_valid;
  logic [NUM_REQ-1:0] grant_vec;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W:0]     cand_sum;
  logic               contend;

  always_comb begin
    x0_hit   = '0;
    nz_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (req_addr[i*REGISTER_INDEX_WIDTH +: REGISTER_INDEX_WIDTH] == '0) x0_hit[i] = 1'b1;
        else nz_valid[i] = 1'b1;
      end
    end
  end

  // First valid non-x0 requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    cand_sum  = '0;
    if (!hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (cand_sum >= (PTR_W+1)'(NUM_REQ)) cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
        if (!grant_any && nz_valid[cand_sum[PTR_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand_sum[PTR_W-1:0];
        end
      end
    end
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  assign contend   = |(nz_valid & ~grant_vec);
  // No handshake may complete while reset is asserted.
  assign req_ready = n_rst ? (x0_hit | grant_vec) : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr_ptr         <= '0;
      rd_wen         <= 1'b0;
      rd_addr        <= '0;
      rd_wdata       <= '0;
      grant_onehot   <= '0;
      contention_cnt <= '0;
    end else begin
      rd_wen       <= grant_any;
      grant_onehot <= grant_vec;
      if (grant_any) begin
        rd_addr  <= req_addr[grant_idx*REGISTER_INDEX_WIDTH +: REGISTER_INDEX_WIDTH];
        rd_wdata <= req_data[grant_idx*XLEN +: XLEN];
        rr_ptr   <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
      if (contend && (contention_cnt != '1)) contention_cnt <= contention_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus reset and saturation sequences.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        n_rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        hold;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [2:0]  grant_onehot;
  logic [15:0] contention_cnt;

  logic [2:0]  sat_ready;
  logic        sat_wen;
  logic [4:0]  sat_addr;
  logic [31:0] sat_wdata;
  logic [2:0]  sat_grant;
  logic [3:0]  sat_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] regs [32];

  regfile_wb_arbiter dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .hold(hold), .rd_wen(rd_wen),
    .rd_addr(rd_addr), .rd_wdata(rd_wdata), .grant_onehot(grant_onehot),
    .contention_cnt(contention_cnt)
  );

  regfile_wb_arbiter #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(sat_ready),
    .req_addr(req_addr), .req_data(req_data), .hold(hold), .rd_wen(sat_wen),
    .rd_addr(sat_addr), .rd_wdata(sat_wdata), .grant_onehot(sat_grant),
    .contention_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream register file fed by the arbiter's write port.
  always @(posedge clk) if (n_rst && rd_wen) regs[rd_addr] <= rd_wdata;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        hold;
    logic [2:0]  ready;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  grant;
    int          inc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] v, logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic h,
                              logic [2:0] rdy, logic w, logic [4:0] ad, logic [31:0] dt,
                              logic [2:0] g, int inc);
    vec_t r;
    r.valid = v; r.a0 = a0; r.a1 = a1; r.a2 = a2;
    r.d0 = d0; r.d1 = d1; r.d2 = d2; r.hold = h;
    r.ready = rdy; r.wen = w; r.addr = ad; r.data = dt; r.grant = g; r.inc = inc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int exp_cnt;

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = '0;
    n_rst = 1'b0; hold = 1'b0;
    req_valid = 3'b001; req_addr = {5'd0, 5'd0, 5'd5}; req_data = {32'h0, 32'h0, 32'hDEADBEEF};

    // Reset held: outputs cleared, ready suppressed even with a valid request.
    #3;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wen", 32'(rd_wen), 32'h0);
    chk("rst_cnt", 32'(contention_cnt), 32'h0);
    #9 n_rst = 1'b1;          // t=12
    #1;
    chk("first_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;       // t=16
    chk("first_wen", 32'(rd_wen), 32'h1);
    chk("first_addr", 32'(rd_addr), 32'h5);
    chk("first_data", rd_wdata, 32'hDEADBEEF);
    chk("first_grant", 32'(grant_onehot), 32'h1);
    req_addr = {5'd0, 5'd0, 5'd6}; req_data = {32'h0, 32'h0, 32'h1234};
    tick;                     // t=26
    chk("inflight_addr", 32'(rd_addr), 32'h6);
    #2 n_rst = 1'b0;          // t=28, mid-write
    #1;
    chk("midrst_wen", 32'(rd_wen), 32'h0);
    chk("midrst_addr", 32'(rd_addr), 32'h0);
    chk("midrst_data", rd_wdata, 32'h0);
    chk("midrst_grant", 32'(grant_onehot), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    #3 n_rst = 1'b1;
    req_valid = 3'b000;
    tick;

    // valid a0 a1 a2 d0 d1 d2 hold | ready wen addr data grant cnt_inc
    for (int r = 0; r < 2; r++) begin
      vecs.push_back(mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 3'b001, 1, 1, 32'hA1, 3'b001, 1));
      vecs.push_back(mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 3'b010, 1, 2, 32'hA2, 3'b010, 1));
      vecs.push_back(mk(3'b111, 1, 2, 3, 32'hA1, 32'hA2, 32'hA3, 0, 3'b100, 1, 3, 32'hA3, 3'b100, 1));
    end
    vecs.push_back(mk(3'b011, 0, 7, 0, 32'hB0, 32'hB7, 32'h0, 0, 3'b011, 1, 7, 32'hB7, 3'b010, 0));
    vecs.push_back(mk(3'b001, 0, 0, 0, 32'hC0, 32'h0, 32'h0, 0, 3'b001, 0, 7, 32'hB7, 3'b000, 0));
    vecs.push_back(mk(3'b111, 10, 11, 12, 32'hD0, 32'hD1, 32'hD2, 0, 3'b100, 1, 12, 32'hD2, 3'b100, 1));
    vecs.push_back(mk(3'b100, 0, 0, 9, 32'h0, 32'h0, 32'hE9, 1, 3'b000, 0, 12, 32'hD2, 3'b000, 1));
    vecs.push_back(mk(3'b100, 0, 0, 9, 32'h0, 32'h0, 32'hE9, 1, 3'b000, 0, 12, 32'hD2, 3'b000, 1));
    vecs.push_back(mk(3'b101, 0, 0, 9, 32'h0, 32'h0, 32'hE9, 1, 3'b001, 0, 12, 32'hD2, 3'b000, 1));
    vecs.push_back(mk(3'b100, 0, 0, 9, 32'h0, 32'h0, 32'hE9, 1, 3'b000, 0, 12, 32'hD2, 3'b000, 1));
    vecs.push_back(mk(3'b100, 0, 0, 9, 32'h0, 32'h0, 32'hE9, 0, 3'b100, 1, 9, 32'hE9, 3'b100, 0));
    vecs.push_back(mk(3'b011, 4, 4, 0, 32'h11, 32'h22, 32'h0, 0, 3'b001, 1, 4, 32'h11, 3'b001, 1));
    vecs.push_back(mk(3'b010, 0, 4, 0, 32'h0, 32'h22, 32'h0, 0, 3'b010, 1, 4, 32'h22, 3'b010, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 3'b000, 0, 4, 32'h22, 3'b000, 0));

    exp_cnt = 0;
    foreach (vecs[i]) begin
      req_valid = vecs[i].valid;
      req_addr  = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      req_data  = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
      hold      = vecs[i].hold;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
      tick;
      exp_cnt += vecs[i].inc;
      chk($sformatf("v%0d_wen", i), 32'(rd_wen), 32'(vecs[i].wen));
      chk($sformatf("v%0d_addr", i), 32'(rd_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_data", i), rd_wdata, vecs[i].data);
      chk($sformatf("v%0d_grant", i), 32'(grant_onehot), 32'(vecs[i].grant));
      chk($sformatf("v%0d_cnt", i), 32'(contention_cnt), 32'(exp_cnt));
    end
    chk("regfile_x4", regs[4], 32'h22);
    chk("regfile_x7", regs[7], 32'hB7);

    // Saturation: 20 cycles of contention under hold.
    n_rst = 1'b0;
    #1 n_rst = 1'b1;
    req_valid = 3'b100; req_addr = {5'd9, 5'd0, 5'd0}; req_data = '0; hold = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (c == 14) chk("sat_cnt14", 32'(sat_cnt), 32'hE);
      if (c == 15) chk("sat_cnt15", 32'(sat_cnt), 32'hF);
    end
    chk("sat_cnt20", 32'(sat_cnt), 32'hF);
    chk("wide_cnt20", 32'(contention_cnt), 32'd20);
    chk("sat_ready", 32'(sat_ready), 32'h0);
    chk("sat_wen", 32'(sat_wen), 32'h0);
    chk("sat_grant", 32'(sat_grant), 32'h0);
    chk("sat_addr", 32'(sat_addr), 32'h0);
    chk("sat_wdata", sat_wdata, 32'h0);
    hold = 1'b0;
    tick;
    chk("sat_release_wen", 32'(sat_wen), 32'h1);
    chk("sat_release_addr", 32'(sat_addr), 32'h9);
    chk("sat_hold_after", 32'(sat_cnt), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port among `NUM_REQ` writeback sources (e.g. ALU, LSU, CSR unit) using round-robin arbitration and a valid/ready handshake per source. Sits between the execute/memory writeback paths and the register file write port (`rd_wen`/`rd_addr`/`rd_wdata`), whose outputs it registers. It also sinks writes to x0 without consuming a write slot and keeps a saturating contention counter for performance analysis.

## Interface
- `XLEN`, 32, data width of each write
- `NUM_REQ`, 3, number of writeback requesters (2..8)
- `CNT_WIDTH`, 16, width of the contention counter

- `clk`  in  1  clock
- `n_rst`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  requester i holds a pending write
- `req_ready`  out  NUM_REQ  requester i's write is accepted this cycle
- `req_addr`  in  NUM_REQ*REGISTER_INDEX_WIDTH  destination index; requester i at `[i*REGISTER_INDEX_WIDTH +: REGISTER_INDEX_WIDTH]`
- `req_data`  in  NUM_REQ*XLEN  write data; requester i at `[i*XLEN +: XLEN]`
- `hold`  in  1  suppresses all non-x0 grants while high
- `rd_wen`  out  1  register file write enable
- `rd_addr`  out  REGISTER_INDEX_WIDTH  register file write index
- `rd_wdata`  out  XLEN  register file write data
- `grant_onehot`  out  NUM_REQ  registered one-hot ID of the source driving the current `rd_*` write
- `contention_cnt`  out  CNT_WIDTH  saturating count of cycles in which a non-x0 request waited

## Operation
- Transfer occurs on requester i when `req_valid[i] && req_ready[i]` at a rising `clk`. A requester holds addr and data stable while valid and not ready.
- **x0 sink:** any valid request with addr == X0 gets `req_ready[i]=1` in the same cycle, regardless of `hold` or arbitration. It takes no part in arbitration and produces no write.
- **Arbitration:** among valid non-x0 requests, grant exactly one using round-robin starting at pointer `rr_ptr`. Search order is `rr_ptr`, `rr_ptr+1`, … mod NUM_REQ. `req_ready` is combinational from `req_valid`, `req_addr`, `hold` and `rr_ptr`.
- **Pointer update:** on a non-x0 grant to i, `rr_ptr <= (i+1) mod NUM_REQ`. Otherwise it is unchanged.
- **hold=1:** no non-x0 grant, `rr_ptr` unchanged, and the next-cycle `rd_wen` is 0.
- **Output stage:** on a non-x0 grant to i, the next cycle has `rd_wen=1`, `rd_addr=req_addr[i]`, `rd_wdata=req_data[i]` and `grant_onehot=1<<i`. With no grant, `rd_wen=0` and `grant_onehot=0`, while `rd_addr`/`rd_wdata` hold their last values.
- **Same-address requests:** both are written in grant order, so the later grant wins in the register file. No merging.
- **Contention counter:** increments when at least one valid non-x0 request is not granted that cycle, including every cycle under `hold`. It saturates at all-ones and never wraps.
- **Reset (asynchronous, n_rst=0):**
  - `rd_wen=0`, `rd_addr=0`, `rd_wdata=0`, `grant_onehot=0`, `contention_cnt=0`, `rr_ptr=0`.
  - `req_ready` is forced to 0 while `n_rst` is low.
  - An in-flight registered write is dropped. An accepted handshake in the reset cycle does not occur.

## Timing
- Grant to register file write: 1 cycle. `rd_*` is valid in the cycle after the handshake, and the register file commits at the following edge.
- Throughput: one non-x0 write per cycle. Any number of x0 sinks can complete in the same cycle alongside it.
- Maximum wait for a continuously valid requester: NUM_REQ-1 grant cycles, excluding `hold` cycles.
- `req_ready` has no dependence on `rd_*` outputs, so there is no combinational loop with downstream logic.
- Deassertion of `n_rst` takes effect at the first rising `clk` after release. The first grant is possible in that cycle.

## Test plan
- **Reset values:** assert `n_rst` mid-write with `rd_wen=1`. All outputs go to 0 immediately without waiting for `clk`, and `req_ready=0`. After release, requester 0 valid with addr 5, data 0xDEADBEEF gives ready in cycle 0 and `rd_wen=1`, `rd_addr=5`, `rd_wdata=0xDEADBEEF`, `grant_onehot=001` in cycle 1.
- **Round-robin fairness:** all 3 requesters continuously valid with addrs 1, 2, 3. Grants cycle 0,1,2,0,1,2 and `rd_addr` sequence is 1,2,3,1,2,3. `contention_cnt` increments every cycle.
- **x0 sink:** req0 has addr 0 and req1 has addr 7, both valid. Both ready in the same cycle, and the next cycle has `rd_wen=1`, `rd_addr=7`. Then req0 alone with addr 0 gives ready=1 and next-cycle `rd_wen=0`, with `rr_ptr` unchanged.
- **hold:** req2 valid with addr 9, `hold=1` for 4 cycles. `req_ready[2]=0`, `rd_wen=0` and counter +4. Drop `hold` and req2 is granted in that cycle, with the write appearing the next cycle.
- **Same-address ordering:** req0 and req1 both target addr 4 with data 0x11 and 0x22 and `rr_ptr=0`. The writes appear as 0x11 then 0x22, and a regfile read of x4 returns 0x22.
- **Counter saturation:** with `CNT_WIDTH=4`, hold contention for 20 cycles. `contention_cnt` sticks at 0xF.
